mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  rising-edge clock; reset  in  1  asynchronous, active-high.
REQ-002 in_valid  in  1  execute/memory pipeline register holds a live instruction.
REQ-003 rs2_val, imm_pc, pc_add4, alu_out, imm  in  32 each  store data, PC+imm target, PC+4, ALU result, U-immediate.
REQ-004 rd  in  5  destination register; esc_reg, esc_mem, jump, branch, lui, jalr, lw  in  1 each  control bits.
REQ-005 stall  out  1  hold the upstream pipeline register.
REQ-006 dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32; dmem_wdata  out  32  data-memory request.
REQ-007 dmem_ack  in  1; dmem_rdata  in  32  data-memory completion and load data.
REQ-008 wb_valid  out  1; wb_we  out  1; wb_rd  out  5; wb_data  out  32  registered write-back stage inputs.
REQ-009 redirect  out  1; redirect_pc  out  32  registered control-flow redirect to fetch.
REQ-010 err_timeout  out  1; err_misalign  out  1  sticky error flags.

Function
REQ-011 States: IDLE and WAIT; 8-bit wait counter.
REQ-012 accept = in_valid AND (state IDLE OR (state WAIT AND dmem_ack)).
REQ-013 stall = state WAIT AND NOT dmem_ack (combinational).
REQ-014 Memory op = lw OR esc_mem; non-memory op otherwise.
REQ-015 Accepted non-memory op retires at the next edge: wb_valid=1 for one cycle.
REQ-016 Accepted non-memory op: wb_we = esc_reg AND rd!=0; wb_rd = rd.
REQ-017 wb_data priority: jump OR jalr -> pc_add4; else lui -> imm; else alu_out.
REQ-018 Accepted memory op with alu_out[1:0]!=0: no request, err_misalign set, retire next edge with wb_we=0.
REQ-019 Accepted aligned memory op: next edge state=WAIT, dmem_req=1.
REQ-020 In WAIT: dmem_addr=alu_out, dmem_we=esc_mem AND NOT lw, dmem_wdata=rs2_val, all captured at accept; held stable until ack.
REQ-021 In WAIT with dmem_ack=1: request retires at next edge.
REQ-022 Load retire: wb_data = dmem_rdata sampled in the ack cycle; wb_we = esc_reg AND rd!=0.
REQ-023 Store retire: wb_valid=1, wb_we=0.
REQ-024 On ack, dmem_req drops at the next edge unless a new aligned memory op is accepted in the same cycle (back-to-back; dmem_req stays 1).
REQ-025 Counter clears on entry to WAIT and increments each WAIT cycle without ack.
REQ-026 Counter reaching 255 without ack: err_timeout set, request abandoned, wb_valid=1, wb_we=0, state IDLE; no accept in that cycle.
REQ-027 Redirect on accept: jalr -> redirect_pc = alu_out with bit0 cleared.
REQ-028 Redirect on accept: jump, or branch with alu_out!=0 -> redirect_pc = imm_pc.
REQ-029 redirect pulses one cycle, registered at the accept edge, independent of memory latency.
REQ-030 wb_valid and redirect are single-cycle pulses; wb_rd, wb_data and redirect_pc hold their last value otherwise.
REQ-031 If two retires would coincide (ack completes A while non-memory B is accepted), A's write-back is emitted first and B is held one cycle in an internal skid register; stall=1 during that cycle.

Reset
REQ-032 Reset forces state IDLE, counter 0 and every output to 0, including both error flags; the flags clear only on reset.
REQ-033 Reset during WAIT abandons the request: dmem_req=0 immediately (asynchronous), and no write-back occurs.

Verification
REQ-034 ALU op alu_out=0x15, rd=3, esc_reg=1 -> next cycle wb_valid=1, wb_we=1, wb_rd=3, wb_data=0x15, stall never 1.
REQ-035 lw at alu_out=0x100, ack after 3 WAIT cycles with rdata=0xDEADBEEF -> stall=1 for 2 cycles, then wb_data=0xDEADBEEF.
REQ-036 sw at alu_out=0x102 -> no dmem_req, err_misalign=1, wb_valid=1, wb_we=0.
REQ-037 jalr with alu_out=0x205 and pc_add4=0x40 -> redirect=1, redirect_pc=0x204, wb_data=0x40.
REQ-038 lw with no ack for 255 cycles -> err_timeout=1, state IDLE, next instruction accepted.
REQ-039 Back-to-back lw, sw, then an ALU op, acks on the first WAIT cycle -> three retires in order, no instruction lost or duplicated.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the pipeline. Issues at most one data-memory
// request at a time, retires instructions to write-back in order, raises
// control-flow redirects and keeps sticky error flags.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] rs2_val,
  input  logic [31:0] imm_pc,
  input  logic [31:0] pc_add4,
  input  logic [31:0] alu_out,
  input  logic [31:0] imm,
  input  logic [4:0]  rd,
  input  logic        esc_reg,
  input  logic        esc_mem,
  input  logic        jump,
  input  logic        branch,
  input  logic        lui,
  input  logic        jalr,
  input  logic        lw,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        err_timeout,
  output logic        err_misalign
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
  // Counter value in the last unacknowledged cycle that still keeps the
  // request alive: the request is abandoned after 255 waiting cycles.
  localparam logic [7:0] CNT_LAST = 8'd254;

  // FSM and wait counter
  logic [0:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  // Outstanding request, captured at accept and held until ack
  logic        req_we_q, req_we_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [4:0]  req_rd_q, req_rd_d;
  logic        req_load_q, req_load_d;
  logic        req_wen_q, req_wen_d;

  // Skid register for a retire that collides with a memory completion
  logic        skid_valid_q, skid_valid_d;
  logic        skid_we_q, skid_we_d;
  logic [4:0]  skid_rd_q, skid_rd_d;
  logic [31:0] skid_data_q, skid_data_d;

  // Registered outputs
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        err_timeout_q, err_timeout_d;
  logic        err_misalign_q, err_misalign_d;

  logic        in_wait;
  logic        ack_done;
  logic        timeout;
  logic        accept;
  logic        mem_op;
  logic        misaligned;
  logic        go_wait;
  logic        imm_retire;
  logic        imm_we;
  logic [31:0] imm_data;

  assign in_wait    = (state_q == ST_WAIT);
  assign ack_done   = in_wait & dmem_ack;
  assign timeout    = in_wait & ~dmem_ack & (cnt_q == CNT_LAST);
  // A held skid retire occupies the write-back slot, so nothing new enters.
  assign accept     = in_valid & ~skid_valid_q & (~in_wait | dmem_ack);
  assign stall      = (in_wait & ~dmem_ack) | skid_valid_q;
  assign mem_op     = lw | esc_mem;
  assign misaligned = (alu_out[1:0] != 2'b00);
  assign go_wait    = accept & mem_op & ~misaligned;
  // Non-memory ops and misaligned memory ops both retire at the next edge.
  assign imm_retire = accept & ~go_wait;
  assign imm_we     = ~mem_op & esc_reg & (rd != 5'd0);
  assign imm_data   = (jump | jalr) ? pc_add4 : (lui ? imm : alu_out);

  assign dmem_req     = in_wait;
  assign dmem_we      = req_we_q;
  assign dmem_addr    = req_addr_q;
  assign dmem_wdata   = req_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_we        = wb_we_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign redirect     = redirect_q;
  assign redirect_pc  = redirect_pc_q;
  assign err_timeout  = err_timeout_q;
  assign err_misalign = err_misalign_q;

  // Request FSM: enter WAIT on an aligned memory op, leave on ack or timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_rd_d    = req_rd_q;
    req_load_d  = req_load_q;
    req_wen_d   = req_wen_q;
    if (in_wait) begin
      if (dmem_ack) begin
        state_d = go_wait ? ST_WAIT : ST_IDLE;
      end else if (timeout) begin
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else if (go_wait) begin
      state_d = ST_WAIT;
    end
    if (go_wait) begin
      cnt_d       = 8'd0;
      req_we_d    = esc_mem & ~lw;
      req_addr_d  = alu_out;
      req_wdata_d = rs2_val;
      req_rd_d    = rd;
      req_load_d  = lw;
      req_wen_d   = lw & esc_reg & (rd != 5'd0);
    end
  end

  // Write-back: skid first, then memory completion/abandon, then direct retire.
  always_comb begin
    wb_valid_d   = 1'b0;
    wb_we_d      = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    skid_valid_d = 1'b0;
    skid_we_d    = skid_we_q;
    skid_rd_d    = skid_rd_q;
    skid_data_d  = skid_data_q;
    if (skid_valid_q) begin
      wb_valid_d = 1'b1;
      wb_we_d    = skid_we_q;
      wb_rd_d    = skid_rd_q;
      wb_data_d  = skid_data_q;
    end else if (ack_done) begin
      wb_valid_d = 1'b1;
      wb_we_d    = req_wen_q;
      wb_rd_d    = req_rd_q;
      if (req_load_q) begin
        wb_data_d = dmem_rdata;
      end
      if (imm_retire) begin
        skid_valid_d = 1'b1;
        skid_we_d    = imm_we;
        skid_rd_d    = rd;
        skid_data_d  = imm_data;
      end
    end else if (timeout) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = req_rd_q;
    end else if (imm_retire) begin
      wb_valid_d = 1'b1;
      wb_we_d    = imm_we;
      wb_rd_d    = rd;
      wb_data_d  = imm_data;
    end
  end

  // Redirect pulse on accept and sticky error flags.
  always_comb begin
    redirect_d     = 1'b0;
    redirect_pc_d  = redirect_pc_q;
    err_timeout_d  = err_timeout_q | timeout;
    err_misalign_d = err_misalign_q | (accept & mem_op & misaligned);
    if (accept) begin
      if (jalr) begin
        redirect_d    = 1'b1;
        redirect_pc_d = {alu_out[31:1], 1'b0};
      end else if (jump | (branch & (alu_out != 32'd0))) begin
        redirect_d    = 1'b1;
        redirect_pc_d = imm_pc;
      end
    end
  end

  // State registers; reset abandons any outstanding request immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 8'd0;
      req_we_q       <= 1'b0;
      req_addr_q     <= 32'd0;
      req_wdata_q    <= 32'd0;
      req_rd_q       <= 5'd0;
      req_load_q     <= 1'b0;
      req_wen_q      <= 1'b0;
      skid_valid_q   <= 1'b0;
      skid_we_q      <= 1'b0;
      skid_rd_q      <= 5'd0;
      skid_data_q    <= 32'd0;
      wb_valid_q     <= 1'b0;
      wb_we_q        <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_data_q      <= 32'd0;
      redirect_q     <= 1'b0;
      redirect_pc_q  <= 32'd0;
      err_timeout_q  <= 1'b0;
      err_misalign_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      req_we_q       <= req_we_d;
      req_addr_q     <= req_addr_d;
      req_wdata_q    <= req_wdata_d;
      req_rd_q       <= req_rd_d;
      req_load_q     <= req_load_d;
      req_wen_q      <= req_wen_d;
      skid_valid_q   <= skid_valid_d;
      skid_we_q      <= skid_we_d;
      skid_rd_q      <= skid_rd_d;
      skid_data_q    <= skid_data_d;
      wb_valid_q     <= wb_valid_d;
      wb_we_q        <= wb_we_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      redirect_q     <= redirect_d;
      redirect_pc_q  <= redirect_pc_d;
      err_timeout_q  <= err_timeout_d;
      err_misalign_q <= err_misalign_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed cases plus randomized traffic against a
// transaction-level model of the memory stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid;
  logic [31:0] rs2_val, imm_pc, pc_add4, alu_out, imm;
  logic [4:0]  rd;
  logic        esc_reg, esc_mem, jump, branch, lui, jalr, lw;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        err_timeout, err_misalign;

  mem_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .rs2_val(rs2_val), .imm_pc(imm_pc), .pc_add4(pc_add4), .alu_out(alu_out), .imm(imm),
    .rd(rd), .esc_reg(esc_reg), .esc_mem(esc_mem), .jump(jump), .branch(branch),
    .lui(lui), .jalr(jalr), .lw(lw), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .err_timeout(err_timeout), .err_misalign(err_misalign)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Retires are produced as transactions (memory completion first, then the
  // op accepted in the same cycle) and emitted one per cycle from a queue.
  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        has_data;
  } ret_t;

  ret_t        pending_wb[$];
  logic        m_busy = 1'b0;
  logic        m_load = 1'b0;
  logic        m_store = 1'b0;
  logic        m_wen = 1'b0;
  logic [4:0]  m_rd = 5'd0;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_wdata = 32'd0;
  int          m_waited = 0;
  logic        m_take;
  ret_t        m_r;
  logic        e_wb_valid = 1'b0;
  ret_t        e_wb = '0;
  logic        e_redir = 1'b0;
  logic [31:0] e_redir_pc = 32'd0;
  logic        e_err_to = 1'b0;
  logic        e_err_mis = 1'b0;
  int          n_accepted = 0;
  int          n_retired = 0;

  // Upstream must hold while a request waits unanswered or a retire is queued.
  function automatic logic exp_stall();
    return (m_busy && !dmem_ack) || (pending_wb.size() != 0);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_wb.delete();
      m_busy     = 1'b0;
      m_waited   = 0;
      m_load     = 1'b0;
      m_store    = 1'b0;
      m_wen      = 1'b0;
      m_rd       = 5'd0;
      m_addr     = 32'd0;
      m_wdata    = 32'd0;
      e_wb_valid = 1'b0;
      e_wb       = '0;
      e_redir    = 1'b0;
      e_redir_pc = 32'd0;
      e_err_to   = 1'b0;
      e_err_mis  = 1'b0;
    end else begin
      m_take = in_valid && !exp_stall();
      if (m_busy) begin
        if (dmem_ack) begin
          m_r.we = m_load && m_wen;
          m_r.rd = m_rd;
          m_r.data = dmem_rdata;
          m_r.has_data = m_load;
          pending_wb.push_back(m_r);
          m_busy = 1'b0;
        end else begin
          m_waited++;
          if (m_waited == 255) begin
            e_err_to = 1'b1;
            m_r = '0;
            pending_wb.push_back(m_r);
            m_busy = 1'b0;
          end
        end
      end
      e_redir = 1'b0;
      if (m_take) begin
        n_accepted++;
        if (jalr) begin
          e_redir = 1'b1;
          e_redir_pc = alu_out & ~32'h1;
        end else if (jump || (branch && alu_out != 32'd0)) begin
          e_redir = 1'b1;
          e_redir_pc = imm_pc;
        end
        if (lw || esc_mem) begin
          if (alu_out % 4 == 0) begin
            m_busy   = 1'b1;
            m_waited = 0;
            m_load   = lw;
            m_store  = esc_mem && !lw;
            m_wen    = esc_reg && (rd != 5'd0);
            m_rd     = rd;
            m_addr   = alu_out;
            m_wdata  = rs2_val;
          end else begin
            e_err_mis = 1'b1;
            m_r = '0;
            pending_wb.push_back(m_r);
          end
        end else begin
          m_r.we = esc_reg && (rd != 5'd0);
          m_r.rd = rd;
          m_r.has_data = 1'b1;
          m_r.data = (jump || jalr) ? pc_add4 : (lui ? imm : alu_out);
          pending_wb.push_back(m_r);
        end
      end
      if (pending_wb.size() != 0) begin
        e_wb_valid = 1'b1;
        e_wb = pending_wb.pop_front();
      end else begin
        e_wb_valid = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_in();
    in_valid = 1'b0; rs2_val = 32'd0; imm_pc = 32'd0; pc_add4 = 32'd0;
    alu_out = 32'd0; imm = 32'd0; rd = 5'd0;
    esc_reg = 1'b0; esc_mem = 1'b0; jump = 1'b0; branch = 1'b0;
    lui = 1'b0; jalr = 1'b0; lw = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    int k;
    idle_in();
    k = $urandom_range(0, 9);
    in_valid = ($urandom_range(0, 3) != 0);
    rd = 5'($urandom_range(0, 31));
    rs2_val = $urandom; imm_pc = $urandom; pc_add4 = $urandom;
    imm = $urandom; alu_out = $urandom;
    esc_reg = ($urandom_range(0, 3) != 0);
    case (k)
      2, 3: lw = 1'b1;
      4, 5: esc_mem = 1'b1;
      6: jump = 1'b1;
      7: jalr = 1'b1;
      8: begin
        branch = 1'b1;
        if ($urandom_range(0, 1) == 0) alu_out = 32'd0;
      end
      9: lui = 1'b1;
      default: ;
    endcase
    if ((lw || esc_mem) && $urandom_range(0, 5) != 0) alu_out[1:0] = 2'b00;
    dmem_ack = ($urandom_range(0, 2) == 0);
    dmem_rdata = $urandom;
  endtask

  // ---------------- main sequence ----------------
  int  n_st;
  bit  got;

  initial begin
    idle_in();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst stall", stall, 0);
    check("rst dmem_req", dmem_req, 0);
    check("rst wb_valid", wb_valid, 0);
    check("rst wb_data", wb_data, 0);
    check("rst redirect_pc", redirect_pc, 0);
    check("rst err_timeout", err_timeout, 0);
    check("rst err_misalign", err_misalign, 0);
    #1 reset = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (!reset) begin
          check("cyc stall", stall, exp_stall());
          check("cyc dmem_req", dmem_req, m_busy);
          if (m_busy) begin
            check("cyc dmem_addr", dmem_addr, m_addr);
            check("cyc dmem_we", dmem_we, m_store);
            check("cyc dmem_wdata", dmem_wdata, m_wdata);
          end
          check("cyc wb_valid", wb_valid, e_wb_valid);
          if (e_wb_valid) begin
            check("cyc wb_we", wb_we, e_wb.we);
            if (e_wb.has_data) begin
              check("cyc wb_rd", wb_rd, e_wb.rd);
              check("cyc wb_data", wb_data, e_wb.data);
            end
          end
          check("cyc redirect", redirect, e_redir);
          if (e_redir) check("cyc redirect_pc", redirect_pc, e_redir_pc);
          check("cyc err_timeout", err_timeout, e_err_to);
          check("cyc err_misalign", err_misalign, e_err_mis);
          if (wb_valid) n_retired++;
        end
      end
    join_none

    // ALU op retires next cycle
    tick(); idle_in(); in_valid = 1'b1; alu_out = 32'h15; rd = 5'd3; esc_reg = 1'b1;
    at_neg(); check("alu stall", stall, 0);
    tick(); idle_in();
    at_neg();
    check("alu wb_valid", wb_valid, 1);
    check("alu wb_we", wb_we, 1);
    check("alu wb_rd", wb_rd, 3);
    check("alu wb_data", wb_data, 32'h15);
    check("alu model data", e_wb.data, 32'h15);
    check("alu stall2", stall, 0);

    // Load acknowledged on the third WAIT cycle
    tick(); idle_in(); in_valid = 1'b1; lw = 1'b1; esc_reg = 1'b1; rd = 5'd5; alu_out = 32'h100;
    tick(); idle_in();
    at_neg();
    check("lw req", dmem_req, 1);
    check("lw addr", dmem_addr, 32'h100);
    check("lw we", dmem_we, 0);
    check("lw stall w1", stall, 1);
    tick();
    at_neg(); check("lw stall w2", stall, 1);
    tick(); dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    at_neg(); check("lw stall w3", stall, 0);
    tick(); idle_in();
    at_neg();
    check("lw wb_valid", wb_valid, 1);
    check("lw wb_we", wb_we, 1);
    check("lw wb_rd", wb_rd, 5);
    check("lw wb_data", wb_data, 32'hDEADBEEF);
    check("lw req drop", dmem_req, 0);

    // Misaligned store
    tick(); idle_in(); in_valid = 1'b1; esc_mem = 1'b1; alu_out = 32'h102; rs2_val = 32'h55;
    tick(); idle_in();
    at_neg();
    check("mis req", dmem_req, 0);
    check("mis err", err_misalign, 1);
    check("mis wb_valid", wb_valid, 1);
    check("mis wb_we", wb_we, 0);

    // jalr redirect with bit0 cleared
    tick(); idle_in(); in_valid = 1'b1; jalr = 1'b1; esc_reg = 1'b1; rd = 5'd1;
    alu_out = 32'h205; pc_add4 = 32'h40;
    tick(); idle_in();
    at_neg();
    check("jalr redirect", redirect, 1);
    check("jalr redirect_pc", redirect_pc, 32'h204);
    check("jalr model pc", e_redir_pc, 32'h204);
    check("jalr wb_data", wb_data, 32'h40);
    tick();
    at_neg();
    check("jalr redirect pulse", redirect, 0);
    check("jalr pc hold", redirect_pc, 32'h204);
    check("jalr data hold", wb_data, 32'h40);

    // Back-to-back lw, sw, ALU with immediate acks
    tick(); idle_in(); in_valid = 1'b1; lw = 1'b1; esc_reg = 1'b1; rd = 5'd6; alu_out = 32'h200;
    tick(); idle_in(); in_valid = 1'b1; esc_mem = 1'b1; alu_out = 32'h300; rs2_val = 32'hCAFE0001;
    dmem_ack = 1'b1; dmem_rdata = 32'h11112222;
    at_neg();
    check("b2b stall1", stall, 0);
    check("b2b addr1", dmem_addr, 32'h200);
    tick(); idle_in(); in_valid = 1'b1; esc_reg = 1'b1; rd = 5'd7; alu_out = 32'h77; dmem_ack = 1'b1;
    at_neg();
    check("b2b lw valid", wb_valid, 1);
    check("b2b lw rd", wb_rd, 6);
    check("b2b lw data", wb_data, 32'h11112222);
    check("b2b req held", dmem_req, 1);
    check("b2b sw addr", dmem_addr, 32'h300);
    check("b2b sw we", dmem_we, 1);
    check("b2b sw wdata", dmem_wdata, 32'hCAFE0001);
    check("b2b stall2", stall, 0);
    tick(); idle_in();
    at_neg();
    check("b2b sw valid", wb_valid, 1);
    check("b2b sw we0", wb_we, 0);
    check("b2b skid stall", stall, 1);
    check("b2b req drop", dmem_req, 0);
    tick();
    at_neg();
    check("b2b alu valid", wb_valid, 1);
    check("b2b alu we", wb_we, 1);
    check("b2b alu rd", wb_rd, 7);
    check("b2b alu data", wb_data, 32'h77);
    check("b2b stall3", stall, 0);
    tick();
    at_neg(); check("b2b no dup", wb_valid, 0);

    // Timeout after 255 unacknowledged WAIT cycles
    tick(); idle_in(); in_valid = 1'b1; lw = 1'b1; esc_reg = 1'b1; rd = 5'd8; alu_out = 32'h400;
    tick(); idle_in();
    n_st = 0; got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      at_neg();
      if (wb_valid) begin
        got = 1'b1;
        break;
      end
      if (stall) n_st++;
    end
    check("to retire seen", got, 1);
    check("to stall cycles", n_st, 255);
    check("to err", err_timeout, 1);
    check("to wb_we", wb_we, 0);
    check("to idle", dmem_req, 0);
    tick(); idle_in(); in_valid = 1'b1; esc_reg = 1'b1; rd = 5'd9; alu_out = 32'h99;
    at_neg(); check("to next stall", stall, 0);
    tick(); idle_in();
    at_neg();
    check("to next valid", wb_valid, 1);
    check("to next data", wb_data, 32'h99);

    // Randomized traffic
    repeat (4000) begin
      tick();
      rand_inputs();
    end
    tick(); idle_in(); dmem_ack = 1'b1;
    repeat (6) tick();
    at_neg();
    check("retire count", n_retired, n_accepted);

    // Reset in WAIT abandons the request asynchronously
    tick(); idle_in(); in_valid = 1'b1; lw = 1'b1; esc_reg = 1'b1; rd = 5'd4; alu_out = 32'h500;
    tick(); idle_in();
    at_neg(); check("ar req before", dmem_req, 1);
    #2 reset = 1'b1;
    #1;
    check("ar req", dmem_req, 0);
    check("ar addr", dmem_addr, 0);
    check("ar wb_valid", wb_valid, 0);
    check("ar wb_data", wb_data, 0);
    check("ar err_timeout", err_timeout, 0);
    check("ar err_misalign", err_misalign, 0);
    check("ar stall", stall, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (3) begin
      at_neg();
      check("ar no wb", wb_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
